// File: rtl/sd_spi_byte_engine.sv
// Avalon-MM byte engine that drives an SD card in SPI mode 0 (MSB first),
// replacing software bit-banging of the sd_clk / sd_cmd / sd_dat3 pins.
module sd_spi_byte_engine #(
    parameter logic [7:0] DIV_RESET = 8'd62
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       sd_clk,
    output logic       sd_cmd,
    input  logic       sd_dat,
    output logic       sd_dat3
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state;
    logic       busy;
    logic       cs_n;
    logic [7:0] clkdiv;
    logic [7:0] cnt;
    logic [3:0] edge_cnt;
    logic [7:0] rx_byte;
    logic [7:0] rx_shift;
    logic [6:0] tx_shift;
    logic       wr_en;

    assign wr_en   = chipselect && !write_n;
    assign sd_dat3 = cs_n;

    // bit 7 goes straight onto sd_cmd at load, so only the remaining seven bits are held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            readdata <= 8'h00;
            sd_clk   <= 1'b0;
            sd_cmd   <= 1'b1;
            busy     <= 1'b0;
            cs_n     <= 1'b1;
            clkdiv   <= DIV_RESET;
            cnt      <= 8'h00;
            edge_cnt <= 4'h0;
            rx_byte  <= 8'h00;
            rx_shift <= 8'h00;
            tx_shift <= 7'h00;
        end else begin
            case (address)
                2'd0:    readdata <= rx_byte;
                2'd1:    readdata <= {6'b0, cs_n, busy};
                2'd2:    readdata <= clkdiv;
                default: readdata <= 8'h00;
            endcase

            case (state)
                IDLE: begin
                    if (wr_en) begin
                        case (address)
                            2'd0: begin
                                state    <= SHIFT;
                                busy     <= 1'b1;
                                sd_cmd   <= writedata[7];
                                tx_shift <= writedata[6:0];
                                cnt      <= 8'h00;
                                edge_cnt <= 4'h0;
                            end
                            2'd1:    cs_n   <= writedata[1];
                            2'd2:    clkdiv <= writedata;
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    if (cnt == clkdiv) begin
                        cnt      <= 8'h00;
                        sd_clk   <= ~sd_clk;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (!sd_clk) begin
                            rx_shift <= {rx_shift[6:0], sd_dat};
                        end else if (edge_cnt == 4'd15) begin
                            rx_byte <= rx_shift;
                            busy    <= 1'b0;
                            sd_cmd  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            sd_cmd   <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Scoreboard bench for sd_spi_byte_engine: per-edge behavioural model, read queue, pin monitor.
module tb_sd_spi_byte_engine;

    localparam int MAXE = 8192;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       sd_clk;
    logic       sd_cmd;
    logic       sd_dat;
    logic       sd_dat3;
    logic       loop_en = 1'b0;
    logic       dat_drv = 1'b0;

    assign sd_dat = loop_en ? sd_cmd : dat_drv;

    sd_spi_byte_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .sd_clk    (sd_clk),
        .sd_cmd    (sd_cmd),
        .sd_dat    (sd_dat),
        .sd_dat3   (sd_dat3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] addr;
        logic [7:0] value;
    } rd_t;

    rd_t rd_q[$];
    bit  exp_valid[MAXE];
    bit  exp_clk[MAXE];
    bit  exp_cmd[MAXE];
    bit  exp_cs[MAXE];

    int vectors = 0;
    int miscompares = 0;

    // Model state, expressed as "transfer started at edge m_k with divider m_D"
    bit         m_cs;
    logic [7:0] m_div;
    logic [7:0] m_rx;
    logic [7:0] m_data;
    logic [7:0] m_bits;
    bit         m_active;
    int         m_k;
    int         m_D;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic budgetCheck(input int n);
        if (n >= MAXE) begin
            miscompares++;
            $display("[TB] FAIL cycle_budget: reached edge %0d, limit %0d", n, MAXE);
            $fatal(1, "[TB] cycle budget exhausted");
        end
    endtask

    task automatic modelReset();
        m_cs     = 1'b1;
        m_div    = 8'd62;
        m_rx     = 8'h00;
        m_data   = 8'h00;
        m_bits   = 8'h00;
        m_active = 1'b0;
        m_k      = 0;
        m_D      = 0;
    endtask

    task automatic markReset(input int n);
        budgetCheck(n);
        exp_valid[n] = 1'b1;
        exp_clk[n]   = 1'b0;
        exp_cmd[n]   = 1'b1;
        exp_cs[n]    = 1'b1;
    endtask

    function automatic logic [7:0] readModel(input logic [1:0] addr);
        case (addr)
            2'd0:    return m_rx;
            2'd1:    return {6'b0, m_cs, m_active};
            2'd2:    return m_div;
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model across edge n; toggle j lands on edge m_k + j*(m_D+1)
    task automatic modelEdge(input int n, input bit wr, input logic [1:0] addr,
                             input logic [7:0] data, input bit d);
        int j;
        int t;
        if (m_active) begin
            if (n > m_k && ((n - m_k) % (m_D + 1)) == 0) begin
                j = (n - m_k) / (m_D + 1);
                if ((j % 2) == 1) m_bits = {m_bits[6:0], d};
                if (j == 16) begin
                    m_rx     = m_bits;
                    m_active = 1'b0;
                end
            end
        end else if (wr) begin
            case (addr)
                2'd0: begin
                    m_active = 1'b1;
                    m_k      = n;
                    m_D      = int'(m_div);
                    m_data   = data;
                    m_bits   = 8'h00;
                end
                2'd1:    m_cs  = data[1];
                2'd2:    m_div = data;
                default: ;
            endcase
        end
        exp_valid[n] = 1'b1;
        exp_cs[n]    = m_cs;
        if (m_active) begin
            t          = (n - m_k) / (m_D + 1);
            exp_clk[n] = ((t % 2) == 1);
            exp_cmd[n] = m_data[7 - t / 2];
        end else begin
            exp_clk[n] = 1'b0;
            exp_cmd[n] = 1'b1;
        end
    endtask

    // Drive one bus cycle shortly after a rising edge; it is sampled at the next one
    task automatic applyStimulus(input bit wr, input bit rd, input logic [1:0] addr,
                                 input logic [7:0] data, input bit dat);
        int  n;
        bit  d;
        rd_t r;
        @(posedge clk);
        #2;
        n = cyc;
        budgetCheck(n);
        d          = loop_en ? exp_cmd[n - 1] : dat;
        dat_drv    = dat;
        chipselect = wr | rd;
        write_n    = !wr;
        address    = addr;
        writedata  = data;
        if (rd) begin
            r.at    = n;
            r.addr  = addr;
            r.value = readModel(addr);
            rd_q.push_back(r);
        end
        modelEdge(n, wr, addr, data, d);
    endtask

    task automatic applyReset(input int cycles);
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_q.delete();
        modelReset();
        markReset(cyc - 1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            markReset(cyc - 1);
        end
        reset_n = 1'b1;
    endtask

    task automatic doWrite(input logic [1:0] addr, input logic [7:0] data, input bit dat);
        applyStimulus(1'b1, 1'b0, addr, data, dat);
    endtask

    task automatic doRead(input logic [1:0] addr, input bit dat);
        applyStimulus(1'b0, 1'b1, addr, 8'h00, dat);
    endtask

    // Monitor: pins against the model every cycle, read data whenever a response is due
    initial begin : monitor
        int  n;
        rd_t r;
        forever begin
            @(negedge clk);
            n = cyc;
            if (n >= 1 && n - 1 < MAXE && exp_valid[n - 1]) begin
                checkOutput("pins{cs_n,sck,mosi}", {5'b0, sd_dat3, sd_clk, sd_cmd},
                            {5'b0, exp_cs[n - 1], exp_clk[n - 1], exp_cmd[n - 1]});
            end
            if (rd_q.size() > 0 && rd_q[0].at == n - 1) begin
                r = rd_q.pop_front();
                checkOutput($sformatf("read_addr%0d", r.addr), readdata, r.value);
            end
        end
    end

    initial begin : stimulus
        modelReset();
        applyReset(3);

        $display("[TB] reset values");
        doRead(2'd2, 1'b0);
        doRead(2'd1, 1'b0);
        doRead(2'd0, 1'b0);
        doRead(2'd3, 1'b0);

        $display("[TB] CLKDIV=0 loopback of 0xA5");
        doWrite(2'd2, 8'h00, 1'b0);
        doWrite(2'd1, 8'h00, 1'b0);
        loop_en = 1'b1;
        doWrite(2'd0, 8'hA5, 1'b0);
        for (int i = 0; i < 18; i++) doRead(2'd1, 1'b0);
        loop_en = 1'b0;
        doRead(2'd0, 1'b0);
        doRead(2'd0, 1'b0);

        $display("[TB] CLKDIV=62 transfer of 0xFF with MISO low");
        doWrite(2'd2, 8'd62, 1'b0);
        doWrite(2'd0, 8'hFF, 1'b0);
        for (int i = 0; i < 1012; i++) doRead(2'd1, 1'b0);
        doRead(2'd0, 1'b0);

        $display("[TB] writes while busy are ignored");
        doWrite(2'd2, 8'd2, 1'b0);
        doWrite(2'd0, 8'h3C, 1'($urandom));
        doWrite(2'd0, 8'h00, 1'($urandom));
        doWrite(2'd2, 8'd5, 1'($urandom));
        doWrite(2'd1, 8'h02, 1'($urandom));
        for (int i = 0; i < 48; i++) doRead(2'($urandom_range(0, 2)), 1'($urandom));
        doRead(2'd2, 1'b0);
        doRead(2'd1, 1'b0);
        doRead(2'd0, 1'b0);

        $display("[TB] reset in the middle of a transfer");
        doWrite(2'd2, 8'd3, 1'b0);
        doWrite(2'd0, 8'($urandom), 1'($urandom));
        for (int i = 0; i < 19; i++) doRead(2'd1, 1'($urandom));
        applyReset(2);
        doRead(2'd0, 1'b0);
        doRead(2'd2, 1'b0);
        doRead(2'd1, 1'b0);

        $display("[TB] randomized bus traffic");
        for (int i = 0; i < 1500; i++) begin
            int         kind;
            logic [1:0] a;
            logic [7:0] v;
            kind = $urandom_range(0, 9);
            a    = 2'($urandom_range(0, 3));
            v    = 8'($urandom);
            if (a == 2'd2) v = 8'($urandom_range(0, 4));
            if (kind < 2)      doWrite(a, v, 1'($urandom));
            else if (kind < 8) doRead(a, 1'($urandom));
            else               applyStimulus(1'b0, 1'b0, a, v, 1'($urandom));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

        @(negedge clk);
        if (rd_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL read_queue_drain: %0d responses outstanding, expected 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
